// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: shared types, region map and size codes for lsu_arbiter.
// Ports: none (package). Provides state_t and region_ok().
package lsu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      FAULT  = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Region map, matched on addr[15:0]
   localparam logic [15:0] DATA_BASE = 16'h2000;
   localparam logic [15:0] DATA_MASK = 16'hE000;
   localparam logic [15:0] OUT_BASE  = 16'h7000;
   localparam logic [15:0] OUT_MASK  = 16'hFFC0;
   localparam logic [15:0] IN_BASE   = 16'h7800;
   localparam logic [15:0] IN_MASK   = 16'hFFE0;

   // Store size codes
   localparam logic [1:0] S_BYTE = 2'b00;
   localparam logic [1:0] S_HALF = 2'b01;
   localparam logic [1:0] S_WORD = 2'b10;

   // Load size codes (LSU encoding; sign handled by l_unsigned)
   localparam logic [2:0] L_BYTE = 3'b000;
   localparam logic [2:0] L_HALF = 3'b001;
   localparam logic [2:0] L_WORD = 3'b010;

   function automatic logic region_ok(
      input logic [15:0] addr,
      input logic        wren,
      input logic [1:0]  s_length,
      input logic [2:0]  l_length
   );
      logic in_data;
      logic in_out;
      logic in_in;
      logic is_word;
      logic is_half;
      logic misalign;
      in_data  = (addr & DATA_MASK) == DATA_BASE;
      in_out   = (addr & OUT_MASK) == OUT_BASE;
      in_in    = (addr & IN_MASK) == IN_BASE;
      is_word  = wren ? (s_length == S_WORD) : (l_length == L_WORD);
      is_half  = wren ? (s_length == S_HALF) : (l_length == L_HALF);
      misalign = (is_word && (addr[1:0] != 2'b00)) ||
                 (is_half && addr[0]);
      // The input region is read-only
      return (in_data || in_out || (in_in && !wren)) && !misalign;
   endfunction

endpackage

// File: rtl/lsu_arb_rr.sv
// lsu_arb_rr: two-input picker holding the last-granted pointer.
// Ports: clk, rst, req[1:0], advance (a grant was taken), grant[1:0] one-hot.
// Macro LSU_ARB_FIXED_PRIO_EN: input 0 always wins ties, pointer dropped.
module lsu_arb_rr #(
   parameter bit RST_LAST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

`ifdef LSU_ARB_FIXED_PRIO_EN

   always_comb begin
      grant = 2'b00;
      if (req[0])
         grant = 2'b01;
      else if (req[1])
         grant = 2'b10;
   end

`else

   // Index of the master granted last
   logic last_q;

   always_ff @(posedge clk) begin
      if (rst)
         last_q <= RST_LAST;
      else if (advance)
         last_q <= grant[1];
   end

   always_comb begin
      grant = 2'b00;
      if (req == 2'b11)
         grant = last_q ? 2'b01 : 2'b10;
      else
         grant = req;
   end

`endif

endmodule

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: shares one LSU command port between M0 (core) and M1 (debug/DMA).
// Ports: i_clk/i_rst, per-master req/payload in and gnt/rvalid/rdata/err out,
// LSU command out (o_lsu_*, o_st_data, o_*_length, o_l_unsigned), i_ld_data in.
// Macro LSU_ARB_FIXED_PRIO_EN selects fixed M0 priority instead of round-robin.
module lsu_arbiter
   import lsu_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter bit RST_LAST = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,

   input  logic              i_m0_req,
   input  logic              i_m0_wren,
   input  logic [ADDR_W-1:0] i_m0_addr,
   input  logic [DATA_W-1:0] i_m0_st_data,
   input  logic [1:0]        i_m0_s_length,
   input  logic [2:0]        i_m0_l_length,
   input  logic              i_m0_l_unsigned,
   output logic              o_m0_gnt,
   output logic              o_m0_rvalid,
   output logic [DATA_W-1:0] o_m0_rdata,
   output logic              o_m0_err,

   input  logic              i_m1_req,
   input  logic              i_m1_wren,
   input  logic [ADDR_W-1:0] i_m1_addr,
   input  logic [DATA_W-1:0] i_m1_st_data,
   input  logic [1:0]        i_m1_s_length,
   input  logic [2:0]        i_m1_l_length,
   input  logic              i_m1_l_unsigned,
   output logic              o_m1_gnt,
   output logic              o_m1_rvalid,
   output logic [DATA_W-1:0] o_m1_rdata,
   output logic              o_m1_err,

   output logic              o_lsu_wren,
   output logic [ADDR_W-1:0] o_lsu_addr,
   output logic [DATA_W-1:0] o_st_data,
   output logic [1:0]        o_s_length,
   output logic [2:0]        o_l_length,
   output logic              o_l_unsigned,
   input  logic [DATA_W-1:0] i_ld_data
);

   state_t state_q;
   state_t state_d;

   logic [1:0] req;
   logic [1:0] req_live;
   logic [1:0] gnt;
   logic       can_gnt;
   logic       fire;

   logic              sel_wren;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_st_data;
   logic [1:0]        sel_s_len;
   logic [2:0]        sel_l_len;
   logic              sel_uns;
   logic              sel_ok;

   logic              id_q;
   logic              wren_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] st_data_q;
   logic [1:0]        s_len_q;
   logic [2:0]        l_len_q;
   logic              uns_q;

   assign req = {i_m1_req, i_m0_req};

   // A new command is taken in IDLE and overlapped with RESP
   assign can_gnt  = ((state_q == IDLE) || (state_q == RESP)) && !i_rst;
   assign req_live = can_gnt ? req : 2'b00;
   assign fire     = |gnt;

   lsu_arb_rr #(
      .RST_LAST (RST_LAST)
   ) u_rr (
      .clk     (i_clk),
      .rst     (i_rst),
      .req     (req_live),
      .advance (fire),
      .grant   (gnt)
   );

   always_comb begin
      sel_wren    = i_m0_wren;
      sel_addr    = i_m0_addr;
      sel_st_data = i_m0_st_data;
      sel_s_len   = i_m0_s_length;
      sel_l_len   = i_m0_l_length;
      sel_uns     = i_m0_l_unsigned;
      if (gnt[1]) begin
         sel_wren    = i_m1_wren;
         sel_addr    = i_m1_addr;
         sel_st_data = i_m1_st_data;
         sel_s_len   = i_m1_s_length;
         sel_l_len   = i_m1_l_length;
         sel_uns     = i_m1_l_unsigned;
      end
   end

   assign sel_ok = region_ok(sel_addr[15:0], sel_wren,
                             sel_s_len, sel_l_len);

   always_ff @(posedge i_clk) begin
      if (i_rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, RESP: begin
            if (fire)
               state_d = sel_ok ? ACCESS : FAULT;
            else
               state_d = IDLE;
         end
         ACCESS, FAULT: state_d = RESP;
         default:       state_d = IDLE;
      endcase
   end

   // Command latch. LSU-facing registers only load for mapped
   // accesses so faults leave the LSU bus untouched.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         id_q      <= 1'b0;
         wren_q    <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         st_data_q <= '0;
         s_len_q   <= '0;
         l_len_q   <= '0;
         uns_q     <= 1'b0;
      end else begin
         if (fire) begin
            id_q   <= gnt[1];
            wren_q <= sel_wren;
            if (sel_ok) begin
               addr_q    <= sel_addr;
               st_data_q <= sel_st_data;
               s_len_q   <= sel_s_len;
               l_len_q   <= sel_l_len;
               uns_q     <= sel_uns;
            end
         end
         if (state_q == ACCESS) begin
            rdata_q <= wren_q ? '0 : i_ld_data;
            err_q   <= 1'b0;
         end else if (state_q == FAULT) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
      end
   end

   always_comb begin
      o_m0_gnt    = gnt[0];
      o_m1_gnt    = gnt[1];
      o_m0_rvalid = 1'b0;
      o_m0_rdata  = '0;
      o_m0_err    = 1'b0;
      o_m1_rvalid = 1'b0;
      o_m1_rdata  = '0;
      o_m1_err    = 1'b0;
      o_lsu_wren  = (state_q == ACCESS) && wren_q && !i_rst;
      if ((state_q == RESP) && !i_rst) begin
         if (id_q) begin
            o_m1_rvalid = 1'b1;
            o_m1_rdata  = rdata_q;
            o_m1_err    = err_q;
         end else begin
            o_m0_rvalid = 1'b1;
            o_m0_rdata  = rdata_q;
            o_m0_err    = err_q;
         end
      end
   end

   assign o_lsu_addr   = addr_q;
   assign o_st_data    = st_data_q;
   assign o_s_length   = s_len_q;
   assign o_l_length   = l_len_q;
   assign o_l_unsigned = uns_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: directed and random stimulus for lsu_arbiter, checked
// cycle by cycle against a transaction-level reference model.
module tb_lsu_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

`ifdef LSU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]    req;
   logic [1:0]    wr;
   logic [1:0]    lu;
   logic [AW-1:0] addr [2];
   logic [DW-1:0] sd [2];
   logic [1:0]    sl [2];
   logic [2:0]    ll [2];
   logic [DW-1:0] ld;

   wire [1:0]    gnt;
   wire [1:0]    rv;
   wire [1:0]    er;
   wire [DW-1:0] rd0;
   wire [DW-1:0] rd1;
   wire          lwren;
   wire [AW-1:0] laddr;
   wire [DW-1:0] lsd;
   wire [1:0]    lsl;
   wire [2:0]    lll;
   wire          luns;

   lsu_arbiter dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_m0_req        (req[0]),
      .i_m0_wren       (wr[0]),
      .i_m0_addr       (addr[0]),
      .i_m0_st_data    (sd[0]),
      .i_m0_s_length   (sl[0]),
      .i_m0_l_length   (ll[0]),
      .i_m0_l_unsigned (lu[0]),
      .o_m0_gnt        (gnt[0]),
      .o_m0_rvalid     (rv[0]),
      .o_m0_rdata      (rd0),
      .o_m0_err        (er[0]),
      .i_m1_req        (req[1]),
      .i_m1_wren       (wr[1]),
      .i_m1_addr       (addr[1]),
      .i_m1_st_data    (sd[1]),
      .i_m1_s_length   (sl[1]),
      .i_m1_l_length   (ll[1]),
      .i_m1_l_unsigned (lu[1]),
      .o_m1_gnt        (gnt[1]),
      .o_m1_rvalid     (rv[1]),
      .o_m1_rdata      (rd1),
      .o_m1_err        (er[1]),
      .o_lsu_wren      (lwren),
      .o_lsu_addr      (laddr),
      .o_st_data       (lsd),
      .o_s_length      (lsl),
      .o_l_length      (lll),
      .o_l_unsigned    (luns),
      .i_ld_data       (ld)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: when the next grant may happen, one pending
   // LSU access and one pending response, plus the last winner.
   int          cyc = 0;
   int          free_at = 0;
   int          last = 1;
   bit          acc_v = 0;
   int          acc_at = 0;
   bit          a_w;
   bit          a_u;
   logic [31:0] a_addr;
   logic [31:0] a_sd;
   logic [1:0]  a_sl;
   logic [2:0]  a_ll;
   bit          rsp_v = 0;
   int          rsp_at = 0;
   int          rsp_m = 0;
   bit          rsp_err;
   logic [31:0] rsp_data;
   logic [1:0]  gexp;
   bit [1:0]    auto_on = 2'b00;
   int          auto_kind [2];
   bit          rnd = 0;
   int          gcnt [2];

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_ok(logic [31:0] a, logic w,
                                 logic [1:0] s, logic [2:0] l);
      int lo;
      int n;
      bit hit;
      lo = int'(a[15:0]);
      if (w)
         n = (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 1;
      else
         n = (l == 3'd1) ? 2 : (l == 3'd2) ? 4 : 1;
      hit = (lo >= 'h2000 && lo < 'h4000) ||
            (lo >= 'h7000 && lo < 'h7040) ||
            (!w && lo >= 'h7800 && lo < 'h7820);
      return hit && (lo % n == 0);
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [15:0] lo;
      logic [15:0] hi;
      hi = 16'($urandom);
      case ($urandom_range(0, 4))
         0:       lo = 16'h2000 + 16'($urandom_range(0, 'h1FFF));
         1:       lo = 16'h7000 + 16'($urandom_range(0, 'h4F));
         2:       lo = 16'h7800 + 16'($urandom_range(0, 'h2F));
         3:       lo = 16'($urandom);
         default: lo = 16'h3FF8 + 16'($urandom_range(0, 15));
      endcase
      return {hi, lo};
   endfunction

   task automatic set_cmd(int m, logic w, logic [31:0] a,
                          logic [31:0] d, logic [1:0] s,
                          logic [2:0] l, logic u);
      req[m]  = 1'b1;
      wr[m]   = w;
      addr[m] = a;
      sd[m]   = d;
      sl[m]   = s;
      ll[m]   = l;
      lu[m]   = u;
   endtask

   task automatic new_cmd(int m, int kind);
      logic [31:0] da;
      da = 32'h2000 + ($urandom_range(0, 2047) << 2);
      case (kind)
         1:       set_cmd(m, 1'b1, da, $urandom, 2'd2, 3'd0, 1'b0);
         2:       set_cmd(m, 1'b0, da, $urandom, 2'd0, 3'd2, 1'b0);
         default: set_cmd(m, 1'($urandom), rand_addr(), $urandom,
                          2'($urandom_range(0, 2)),
                          3'($urandom_range(0, 2)), 1'($urandom));
      endcase
   endtask

   task automatic eval();
      logic [1:0]  erv;
      logic [1:0]  eer;
      logic        ew;
      logic [31:0] erd0;
      logic [31:0] erd1;
      int          w;
      bit          ok;
      erv  = 2'b00;
      eer  = 2'b00;
      ew   = 1'b0;
      erd0 = '0;
      erd1 = '0;
      gexp = 2'b00;
      gcnt[0] += int'(gnt[0]);
      gcnt[1] += int'(gnt[1]);
      if (rsp_v && rsp_at == cyc) begin
         erv[rsp_m] = 1'b1;
         eer[rsp_m] = rsp_err;
         if (rsp_m == 0) erd0 = rsp_data;
         else            erd1 = rsp_data;
         rsp_v = 0;
      end
      if (acc_v && acc_at == cyc) begin
         ew = a_w;
         chk("lsu_addr", laddr, a_addr);
         chk("lsu_st_data", lsd, a_sd);
         chk("lsu_s_length", lsl, a_sl);
         chk("lsu_l_length", lll, a_ll);
         chk("lsu_l_unsigned", luns, a_u);
         rsp_data = a_w ? 32'h0 : ld;
         acc_v = 0;
      end
      if (cyc >= free_at && req != 2'b00) begin
         if (req == 2'b11)
            w = FIXED ? 0 : 1 - last;
         else
            w = req[1] ? 1 : 0;
         gexp[w]  = 1'b1;
         last     = w;
         free_at  = cyc + 2;
         ok       = ref_ok(addr[w], wr[w], sl[w], ll[w]);
         acc_v    = ok;
         acc_at   = cyc + 1;
         a_w      = wr[w];
         a_u      = lu[w];
         a_addr   = addr[w];
         a_sd     = sd[w];
         a_sl     = sl[w];
         a_ll     = ll[w];
         rsp_v    = 1;
         rsp_at   = cyc + 2;
         rsp_m    = w;
         rsp_err  = !ok;
         rsp_data = '0;
      end
      chk("gnt", gnt, gexp);
      chk("lsu_wren", lwren, ew);
      chk("rvalid", rv, erv);
      chk("err", er, eer);
      chk("rdata0", rd0, erd0);
      chk("rdata1", rd1, erd1);
   endtask

   task automatic step();
      @(negedge clk);
      eval();
      @(posedge clk);
      #1;
      cyc++;
      for (int m = 0; m < 2; m++) begin
         if (gexp[m]) begin
            req[m] = 1'b0;
            if (auto_on[m]) new_cmd(m, auto_kind[m]);
         end
         if (rnd) begin
            if (!req[m] && $urandom_range(0, 9) < 4)
               new_cmd(m, 0);
            else if (req[m] && $urandom_range(0, 31) == 0)
               req[m] = 1'b0;
         end
      end
      if (rnd) ld = $urandom;
   endtask

   task automatic do_reset();
      req = 2'b00;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      acc_v   = 0;
      rsp_v   = 0;
      last    = 1;
      free_at = cyc;
      @(negedge clk);
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_rvalid", rv, 2'b00);
      chk("rst_err", er, 2'b00);
      chk("rst_rdata0", rd0, 32'h0);
      chk("rst_rdata1", rd1, 32'h0);
      chk("rst_lsu_wren", lwren, 1'b0);
      chk("rst_lsu_addr", laddr, 32'h0);
      chk("rst_st_data", lsd, 32'h0);
      chk("rst_s_length", lsl, 2'b00);
      chk("rst_l_length", lll, 3'b000);
      chk("rst_l_unsigned", luns, 1'b0);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      rst = 1'b1;
      req = 2'b00;
      wr  = 2'b00;
      lu  = 2'b00;
      ld  = '0;
      for (int m = 0; m < 2; m++) begin
         addr[m]      = '0;
         sd[m]        = '0;
         sl[m]        = '0;
         ll[m]        = '0;
         auto_kind[m] = 0;
         gcnt[m]      = 0;
      end
      do_reset();

      // Tie on loads of 0x2000: M0 first, M1 two cycles later
      ld = 32'hDEADBEEF;
      set_cmd(0, 1'b0, 32'h2000, 32'h0, 2'd0, 3'd2, 1'b0);
      set_cmd(1, 1'b0, 32'h2000, 32'h0, 2'd0, 3'd2, 1'b0);
      repeat (6) step();

      // M0 store stream with a single M1 load in between
      auto_kind[0] = 1;
      auto_on[0]   = 1'b1;
      new_cmd(0, 1);
      set_cmd(1, 1'b0, 32'h2100, 32'h0, 2'd0, 3'd2, 1'b0);
      repeat (8) step();
      auto_on[0] = 1'b0;
      repeat (4) step();

      // Faults: store to input region, load from unmapped space
      set_cmd(1, 1'b1, 32'h7802, 32'h12345678, 2'd2, 3'd0, 1'b0);
      repeat (3) step();
      set_cmd(1, 1'b0, 32'h9000, 32'h0, 2'd0, 3'd2, 1'b0);
      repeat (3) step();

      // Half-word unsigned load from the output region
      ld = 32'h0000ABCD;
      set_cmd(0, 1'b0, 32'h7010, 32'h0, 2'd0, 3'd1, 1'b1);
      repeat (3) step();

      // Reset while the LSU access is in progress
      set_cmd(0, 1'b0, 32'h2004, 32'h0, 2'd0, 3'd2, 1'b0);
      step();
      do_reset();
      step();
      set_cmd(0, 1'b0, 32'h2008, 32'h0, 2'd0, 3'd2, 1'b0);
      set_cmd(1, 1'b0, 32'h200C, 32'h0, 2'd0, 3'd2, 1'b0);
      repeat (4) step();

      // Ten cycles of continuous requests from both masters
      do_reset();
      gcnt[0]      = 0;
      gcnt[1]      = 0;
      auto_kind[0] = 2;
      auto_kind[1] = 2;
      auto_on      = 2'b11;
      new_cmd(0, 2);
      new_cmd(1, 2);
      repeat (10) step();
      auto_on = 2'b00;
      req     = 2'b00;
`ifdef LSU_ARB_FIXED_PRIO_EN
      chk("m0_grants", 64'(gcnt[0]), 64'd5);
      chk("m1_grants", 64'(gcnt[1]), 64'd0);
`else
      chk("m0_grants", 64'(gcnt[0]), 64'd3);
      chk("m1_grants", 64'(gcnt[1]), 64'd2);
`endif
      repeat (3) step();

      // Random traffic with occasional resets
      auto_kind[0] = 0;
      auto_kind[1] = 0;
      rnd = 1;
      repeat (800) begin
         step();
         if ($urandom_range(0, 299) == 0) do_reset();
      end
      rnd = 0;
      req = 2'b00;
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
